// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that streams operand nibbles, LSB first, through
// a single 4-bit carry-lookahead slice, chaining the slice carry between cycles.

module CLA_4bit (
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic [4:0] carry
);

    logic [3:0] p;
    logic [3:0] g;

    assign p = in1 ^ in2;
    assign g = in1 & in2;

    // Flattened lookahead equations; carry[k] is the carry into bit k.
    assign carry[0] = c_in;
    assign carry[1] = g[0] | (p[0] & c_in);
    assign carry[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign carry[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & c_in);
    assign carry[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0])
                    | (p[3] & p[2] & p[1] & p[0] & c_in);

    assign sum = p ^ carry[3:0];

endmodule

module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int unsigned N     = WIDTH / 4;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cy_q, cy_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [3:0]         cla_sum;
    logic [4:0]         cla_carry;
    logic               cla_c4;
    logic               cla_c3;
    logic [2:0]         cla_carry_unused;

    CLA_4bit u_cla (
        .in1   (a_sh_q[3:0]),
        .in2   (b_sh_q[3:0]),
        .c_in  (cy_q),
        .sum   (cla_sum),
        .carry (cla_carry)
    );

    assign {cla_c4, cla_c3, cla_carry_unused} = cla_carry;

    // State register and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath control; DONE accepts a new start like IDLE
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    cy_d    = c_in;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sh_d = a_sh_q >> 4;
                b_sh_d = b_sh_q >> 4;
                res_d  = (res_q >> 4) | (WIDTH'(cla_sum) << (WIDTH - 4));
                cy_d   = cla_c4;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    c_out_d = cla_c4;
                    ovf_d   = cla_c4 ^ cla_c3;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = res_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: stimulus pushes expected results,
// a negedge monitor pops and checks them whenever done is seen.

module tb_nibble_serial_adder;

    localparam int unsigned W = 16;
    localparam int unsigned N = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           due;
    } exp_t;

    exp_t sb[$];

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sum", 32'(sum), 32'(e.s));
                check("c_out", 32'(c_out), 32'(e.co));
                check("overflow", 32'(overflow), 32'(e.ov));
                check("done_latency", 32'(cyc), 32'(e.due));
                check("busy_in_done", 32'(busy), 32'(0));
            end
        end
    end

    // One start pulse; result due N edges after the sampling edge
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input logic [W-1:0] es, input logic eco, input logic eov);
        @(negedge clk);
        a = ta; b = tb_v; c_in = tc; start = 1'b1;
        sb.push_back('{es, eco, eov, cyc + 1 + int'(N)});
        @(negedge clk);
        start = 1'b0;
        a = ~ta; b = ~tb_v; c_in = ~tc;
        check("busy_after_start", 32'(busy), 32'(1));
        repeat (N + 2) @(negedge clk);
        check("sum_held", 32'(sum), 32'(es));
        check("c_out_held", 32'(c_out), 32'(eco));
    endtask

    initial begin
        int k;

        // Reset with arbitrary inputs
        a = 16'hDEAD; b = 16'hBEEF; c_in = 1'b1; start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_sum", 32'(sum), 32'(0));
        check("rst_c_out", 32'(c_out), 32'(0));
        check("rst_overflow", 32'(overflow), 32'(0));
        start = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_op(16'h0400, 16'h0C00, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op(16'h89AB, 16'h7654, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Start pulse during RUN must be ignored
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; c_in = 1'b0; start = 1'b1;
        sb.push_back('{16'h5555, 1'b0, 1'b0, cyc + 1 + int'(N)});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (N + 3) @(negedge clk);
        check("ignored_start_sum", 32'(sum), 32'(16'h5555));

        // Start held high: second op accepted in the DONE cycle
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; c_in = 1'b0; start = 1'b1;
        k = cyc;
        sb.push_back('{16'h0002, 1'b0, 1'b0, k + 1 + int'(N)});
        sb.push_back('{16'h0004, 1'b0, 1'b0, k + 2 + 2 * int'(N)});
        @(negedge clk);
        a = 16'h0002; b = 16'h0002;
        repeat (N + 1) @(negedge clk);
        start = 1'b0;
        repeat (N + 3) @(negedge clk);

        // Mid-operation reset: prior c_out/overflow are 1, partial sum is nonzero
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_done", 32'(done), 32'(0));
        check("midrst_sum", 32'(sum), 32'(0));
        check("midrst_c_out", 32'(c_out), 32'(0));
        check("midrst_overflow", 32'(overflow), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (N + 3) @(negedge clk);
        run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        check("pending_results", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder that feeds operand nibbles, LSB first, into one `CLA_4bit` instance. It registers each 4-bit sum slice and chains the CLA's `carry[4]` back into `c_in` on the next cycle. The block is the sequencing stage directly upstream of `CLA_4bit`, and it consumes that stage's `sum` and `carry` outputs. It trades latency (WIDTH/4 cycles) for area: one 4-bit CLA serves any operand width.

## Interface
- `WIDTH`, 16: operand/result width in bits; must be a multiple of 4 and at least 4. N = WIDTH/4 nibbles.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: request; sampled only when `busy`=0.
- `a` input WIDTH: operand A; captured on an accepted start.
- `b` input WIDTH: operand B; captured on an accepted start.
- `c_in` input 1: carry-in to nibble 0; captured on an accepted start.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse; the result is valid.
- `sum` output WIDTH: result of a + b + c_in, modulo 2^WIDTH.
- `c_out` output 1: carry out of bit WIDTH-1.
- `overflow` output 1: two's-complement overflow, computed as carry into MSB XOR `c_out`.

## Operation
- Internal state: `a_sh`, `b_sh` (WIDTH-bit shift registers), `cy` (1-bit carry), `cnt` (counts 0..N-1, width clog2(N), minimum 1), result shift register, FSM.
- `CLA_4bit` is instantiated combinationally with `in1`=`a_sh[3:0]`, `in2`=`b_sh[3:0]` and `c_in`=`cy`.
- The FSM has three states: IDLE, RUN, DONE.
  - IDLE: `busy`=0, `done`=0. If `start`=1, load `a_sh`←`a`, `b_sh`←`b`, `cy`←`c_in`, `cnt`←0, then go to RUN.
  - RUN: `busy`=1. Each cycle:
    - shift `a_sh` and `b_sh` right by 4;
    - shift the result register right by 4, inserting CLA `sum` at bits [WIDTH-1:WIDTH-4];
    - set `cy`←CLA `carry[4]`;
    - increment `cnt`.
  - RUN exit: when `cnt`=N-1, also set `c_out`←`carry[4]` and `overflow`←`carry[4]`^`carry[3]`, then go to DONE.
  - DONE: `done`=1, `busy`=0, for exactly one cycle. If `start`=1 in DONE, it is accepted exactly as in IDLE and the next state is RUN; otherwise the next state is IDLE.
- `start` is ignored while in RUN. The operands are not sampled.
- `sum`, `c_out` and `overflow` are driven from registers. They update only during RUN and the RUN exit cycle, and hold their value through DONE and IDLE until the next RUN overwrites them.
- Input operands may change freely after an accepted start.

## Timing
- Reset values: FSM=IDLE, `busy`=0, `done`=0, `sum`=0, `c_out`=0, `overflow`=0, `cnt`=0, `cy`=0, `a_sh`=0, `b_sh`=0.
- Latency: call the edge that samples `start` E0. Nibble k is registered at edge E(k+1). `done` is high for the cycle following E(N), and `sum`/`c_out`/`overflow` are final from E(N) onward.
- Throughput: with `start` held high, one result every N+1 cycles, since the DONE cycle overlaps the next accept.
- Intermediate `sum` values during RUN are partial and must not be used before `done`.
- `rst` asserted at any time, including mid-RUN, immediately forces all reset values; the in-flight operation is discarded. After release, the first accepted `start` behaves normally.
- The CLA path is purely combinational within one cycle. No multicycle constraints apply.

## Test plan
- Reset: assert `rst` with arbitrary inputs → `busy`=0, `done`=0, `sum`=0x0000, `c_out`=0, `overflow`=0.
- Basic add, WIDTH=16: a=0x1234, b=0x4321, c_in=0, `start` pulse → `busy` high for 4 cycles, then `done`=1 for 1 cycle with `sum`=0x5555, `c_out`=0, `overflow`=0; results held after `done`.
- Full carry ripple across nibbles: a=0xFFFF, b=0x0000, c_in=1 → `sum`=0x0000, `c_out`=1, `overflow`=0. Then a=0x0400, b=0x0C00, c_in=0 → `sum`=0x1000, `c_out`=0.
- Signed overflow: a=0x7FFF, b=0x0001, c_in=0 → `sum`=0x8000, `c_out`=0, `overflow`=1. Then a=0x8000, b=0x8000 → `sum`=0x0000, `c_out`=1, `overflow`=1.
- Handshake:
  - Pulse `start` with new operands during RUN → ignored; the first result is unchanged.
  - Hold `start`=1 with a=0x0001, b=0x0001 then a=0x0002, b=0x0002 → the first `done` shows 0x0002. The second operation is accepted in the DONE cycle, and the second `done` arrives 5 cycles after the first with `sum`=0x0004.
- Reset mid-operation: assert `rst` 2 cycles after `start` → outputs return to reset values and no `done` is issued. After release, a=0x00FF, b=0x0001 → `sum`=0x0100 after 4 cycles.
